// File: rtl/uart_pkg.sv
// uart_pkg: sequencer state encoding and timing constants shared by the UART feeder
package uart_pkg;
  typedef enum logic [3:0] {
    INIT,
    IDLE,
    LOAD,
    START_GAP,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    STOP,
    STOP_GAP
  } state_t;
  localparam int GAP_CYCLES = 1;
endpackage

// File: rtl/uart_tx_feeder_if.sv
// uart_tx_feeder_if: valid/ready byte push port into the feeder
interface uart_tx_feeder_if;
  logic       valid;
  logic [7:0] data;
  logic       ready;
  modport master(output valid, data, input ready);
  modport slave(input valid, data, output ready);
endinterface

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: circular buffer with extra-MSB pointers; level/full/empty derive from pointers only
module uart_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  logic [WIDTH-1:0]        wdata,
  output logic [WIDTH-1:0]        rdata,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    full,
  output logic                    empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = wr_ptr[AW] != rd_ptr[AW] && wr_ptr[AW-1:0] == rd_ptr[AW-1:0];
  assign empty = wr_ptr == rd_ptr;
  assign level = wr_ptr - rd_ptr;
  assign rdata = mem[rd_ptr[AW-1:0]];
  // a push coinciding with flush is dropped
  assign do_push = push && !full && !flush;
  assign do_pop = pop && !empty;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: buffers pushed bytes and drives the UART data/control strobe sequence per byte
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int TIMEOUT = 2**20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  uart_tx_feeder_if.slave        push,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] level,
  output logic                   uart_wr_data,
  output logic [7:0]             uart_data,
  output logic                   uart_wr_cr,
  output logic                   uart_tx_en,
  output logic                   uart_tx_start,
  input  logic                   uart_tx_busy,
  input  logic                   uart_tx_done,
  output logic                   err
);
  localparam int CW = $clog2(TIMEOUT);
  state_t state, next;
  logic [CW-1:0] cnt;
  logic [1:0] busy_sync, done_sync;
  logic [7:0] head;
  logic busy_s, done_s, full, empty, pop, waiting, timeout;
  uart_sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push.valid),
    .pop(pop),
    .flush(flush),
    .wdata(push.data),
    .rdata(head),
    .level(level),
    .full(full),
    .empty(empty)
  );
  assign push.ready = !full;
  assign busy_s = busy_sync[1];
  assign done_s = done_sync[1];
  assign pop = state == IDLE && !empty;
  assign waiting = state == WAIT_BUSY || state == WAIT_DONE;
  assign timeout = waiting && cnt == CW'(TIMEOUT - 1);
  always_comb begin
    next = state;
    case (state)
      INIT:      next = IDLE;
      IDLE:      next = empty ? IDLE : LOAD;
      LOAD:      next = START_GAP;
      START_GAP: next = START;
      START:     next = WAIT_BUSY;
      WAIT_BUSY: next = timeout ? STOP : busy_s ? WAIT_DONE : WAIT_BUSY;
      WAIT_DONE: next = timeout || done_s || !busy_s ? STOP : WAIT_DONE;
      STOP:      next = STOP_GAP;
      STOP_GAP:  next = IDLE;
      default:   next = INIT;
    endcase
  end
  // strobes are registered from the current state, so each lands one cycle after its state
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= INIT;
      cnt <= '0;
      busy_sync <= '0;
      done_sync <= '0;
      err <= 1'b0;
      uart_wr_data <= 1'b0;
      uart_data <= '0;
      uart_wr_cr <= 1'b0;
      uart_tx_en <= 1'b0;
      uart_tx_start <= 1'b0;
    end else begin
      state <= next;
      cnt <= waiting && next == state ? cnt + 1'b1 : '0;
      busy_sync <= {busy_sync[0], uart_tx_busy};
      done_sync <= {done_sync[0], uart_tx_done};
      err <= err | timeout;
      uart_wr_data <= state == LOAD;
      uart_wr_cr <= state inside {INIT, START, STOP};
      uart_tx_en <= 1'b1;
      uart_tx_start <= state == START;
      if (pop) uart_data <= head;
    end
endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: directed and randomized checks of uart_tx_feeder against a byte-queue
// scoreboard and a behavioural transmitter model
module tb_uart_tx_feeder;
  localparam int DEPTH = 16;
  localparam int TIMEOUT = 64;
  logic clk = 0, rst_n, flush = 0;
  logic uart_tx_busy = 0, uart_tx_done = 0;
  logic [4:0] level;
  logic uart_wr_data, uart_wr_cr, uart_tx_en, uart_tx_start, err;
  logic [7:0] uart_data;
  uart_tx_feeder_if bus();
  uart_tx_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .push(bus),
    .flush(flush),
    .level(level),
    .uart_wr_data(uart_wr_data),
    .uart_data(uart_data),
    .uart_wr_cr(uart_wr_cr),
    .uart_tx_en(uart_tx_en),
    .uart_tx_start(uart_tx_start),
    .uart_tx_busy(uart_tx_busy),
    .uart_tx_done(uart_tx_done),
    .err(err)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_err = 0;
  logic [7:0] exp_q[$];
  int pushed = 0, popped = 0, wd_cnt = 0;
  bit hold = 0, nobusy = 0, rnd = 0, active = 0;
  int ucnt = 0, bdel = 3, ddel = 20;
  logic prev_wd = 0, prev_cr = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  // model accepts a push whenever its own byte count says there is room
  task automatic push_byte(input logic [7:0] b);
    bit ok;
    ok = pushed - popped < DEPTH;
    bus.valid = 1;
    bus.data = b;
    check("push_ready", bus.ready, ok);
    @(posedge clk);
    #1;
    if (ok) begin
      exp_q.push_back(b);
      pushed++;
    end
    bus.valid = 0;
  endtask
  // which: 0 data strobe, 1 start control write, 2 control write with start clear
  task automatic wait_for(input int which, input string tag);
    int t;
    bit hit;
    t = 0;
    hit = 0;
    while (!hit && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
      hit = which == 0 ? uart_wr_data : uart_wr_cr && uart_tx_start == (which == 1);
    end
    check(tag, hit, 1);
  endtask
  // transmitter: busy some cycles after a start write, then done and idle
  always @(negedge clk) begin
    if (uart_wr_cr) begin
      active = uart_tx_start;
      ucnt = 0;
      uart_tx_busy = 0;
      uart_tx_done = 0;
      bdel = rnd ? int'($urandom_range(1, 6)) : 3;
      ddel = rnd ? int'($urandom_range(1, 25)) : 20;
    end else if (active && !nobusy) begin
      ucnt++;
      if (ucnt == bdel) uart_tx_busy = 1;
      if (!hold && ucnt >= bdel + ddel) begin
        uart_tx_busy = 0;
        uart_tx_done = 1;
        active = 0;
      end
    end
  end
  // scoreboard: every data strobe carries the oldest queued byte
  always @(negedge clk) begin
    if (uart_wr_data) begin
      wd_cnt++;
      check("wd_pulse", prev_wd, 0);
      check("byte_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        check("uart_data", uart_data, exp_q.pop_front());
        popped++;
        check("level_at_pop", level, pushed - popped);
      end
    end
    if (uart_wr_cr) begin
      check("cr_pulse", prev_cr, 0);
      check("cr_tx_en", uart_tx_en, 1);
    end
    prev_wd = uart_wr_data;
    prev_cr = uart_wr_cr;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish within 50000 cycles");
    $fatal(1);
  end
  initial begin
    int t, n;
    logic [3:0] wd_s, cr_s;
    bus.valid = 0;
    bus.data = 0;
    rst_n = 1;
    #1 rst_n = 0;
    #1;
    check("rst_ready", bus.ready, 1);
    check("rst_level", level, 0);
    check("rst_outs", {uart_wr_data, uart_wr_cr, uart_tx_en, uart_tx_start, err}, 0);
    check("rst_data", uart_data, 0);
    cyc(3);
    rst_n = 1;
    wait_for(2, "init_cr");
    check("init_tx_en", uart_tx_en, 1);
    cyc(2);
    // single byte with fixed transmitter timing
    push_byte(8'h55);
    for (int k = 0; k < 4; k++) begin
      cyc(1);
      wd_s[k] = uart_wr_data;
      cr_s[k] = uart_wr_cr & uart_tx_start;
    end
    check("t1_wd_timing", wd_s, 4'b0010);
    check("t1_cr_timing", cr_s, 4'b1000);
    t = 0;
    while (!uart_tx_done && t < 100) begin
      cyc(1);
      t++;
    end
    check("t1_done_seen", t < 100, 1);
    t = 0;
    while (!(uart_wr_cr && !uart_tx_start) && t < 20) begin
      cyc(1);
      t++;
    end
    check("t1_stop_lat", t, 3);
    check("t1_err", err, 0);
    cyc(2);
    check("t1_level", level, 0);
    // fill while the transmitter is stalled
    hold = 1;
    push_byte(8'hEE);
    wait_for(1, "t2_start");
    cyc(10);
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    check("t2_level_full", level, 16);
    check("t2_ready_full", bus.ready, 0);
    push_byte(8'h10);
    check("t2_level_still", level, 16);
    hold = 0;
    repeat (17) wait_for(2, "t2_drain");
    cyc(2);
    check("t2_level_empty", level, 0);
    check("t2_sb_empty", exp_q.size(), 0);
    // push lands on the pop edge at level 5
    hold = 1;
    push_byte(8'hC0);
    wait_for(1, "t3_start");
    cyc(10);
    for (int i = 0; i < 5; i++) push_byte(8'hD0 + 8'(i));
    check("t3_level5", level, 5);
    hold = 0;
    wait_for(2, "t3_stop");
    cyc(1);
    check("t3_level_pre", level, 5);
    push_byte(8'h77);
    check("t3_level_pushpop", level, 5);
    repeat (6) wait_for(2, "t3_drain");
    cyc(2);
    check("t3_level_empty", level, 0);
    // flush with a byte in flight and three queued
    hold = 1;
    push_byte(8'hA1);
    wait_for(1, "t4_start");
    cyc(10);
    for (int i = 0; i < 3; i++) push_byte(8'hB1 + 8'(i));
    check("t4_level3", level, 3);
    flush = 1;
    bus.valid = 1;
    bus.data = 8'h99;
    cyc(1);
    flush = 0;
    bus.valid = 0;
    exp_q.delete();
    pushed = popped;
    check("t4_level_flush", level, 0);
    check("t4_ready", bus.ready, 1);
    n = wd_cnt;
    hold = 0;
    wait_for(2, "t4_stop");
    cyc(40);
    check("t4_no_wd", wd_cnt, n);
    check("t4_level_end", level, 0);
    check("t4_err", err, 0);
    // random bytes, gaps and transmitter timing
    rnd = 1;
    for (int i = 0; i < 48; i++) begin
      cyc($urandom_range(0, 6));
      t = 0;
      while (pushed - popped >= DEPTH && t < 3000) begin
        cyc(1);
        t++;
      end
      push_byte(8'($urandom));
    end
    t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      cyc(1);
      t++;
    end
    check("t5_drained", exp_q.size(), 0);
    wait_for(2, "t5_last_stop");
    cyc(2);
    check("t5_level", level, 0);
    check("t5_err", err, 0);
    rnd = 0;
    // dead transmitter: busy never rises
    nobusy = 1;
    push_byte(8'h3C);
    push_byte(8'h3D);
    wait_for(1, "t6_start");
    cyc(63);
    check("t6_err_early", err, 0);
    cyc(1);
    check("t6_err", err, 1);
    cyc(1);
    check("t6_stop", uart_wr_cr & ~uart_tx_start, 1);
    nobusy = 0;
    wait_for(2, "t6_next_stop");
    check("t6_next_sent", exp_q.size(), 0);
    check("t6_err_sticky", err, 1);
    // reset in the middle of a byte
    hold = 1;
    push_byte(8'hE7);
    push_byte(8'hE8);
    push_byte(8'hE9);
    wait_for(1, "t7_start");
    cyc(10);
    rst_n = 0;
    #1;
    check("t7_outs", {uart_wr_data, uart_wr_cr, uart_tx_en, uart_tx_start, err}, 0);
    check("t7_data", uart_data, 0);
    check("t7_level", level, 0);
    check("t7_ready", bus.ready, 1);
    exp_q.delete();
    pushed = popped;
    cyc(2);
    rst_n = 1;
    wait_for(2, "t7_init");
    check("t7_init_en", uart_tx_en, 1);
    check("t7_init_level", level, 0);
    hold = 0;
    n = wd_cnt;
    cyc(30);
    check("t7_no_wd", wd_cnt, n);
    check("t7_err", err, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uart_tx_feeder.md
# uart_tx_feeder

Byte-buffering front end that sits directly upstream of the UART block's transmit path. It accepts bytes from the core over a valid/ready push port and stores them in an internal FIFO. It sequences the UART's edge-detected strobes (data write, then control write with start set, then control write with start cleared) to send each byte, using resynchronised transmitter status to pace the sequence. It relieves software of polling txBusy/txDone per byte.

## Interface
- DEPTH, 16: FIFO entries; power of two, ≥2.
- TIMEOUT, 2**20: max clk cycles spent in either WAIT state before the error exit.
- clk  in  1  system clock, same clock as the UART register side.
- rst_n  in  1  reset, asynchronous assert, active-low.
- push_valid  in  1  byte offered.
- push_data  in  8  byte to send.
- push_ready  out  1  FIFO not full; a push is accepted when push_valid & push_ready.
- flush  in  1  single-cycle request to discard all queued bytes.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- uart_wr_data  out  1  data-write strobe to UART.
- uart_data  out  8  byte driven with uart_wr_data; held until the next LOAD.
- uart_wr_cr  out  1  control-write strobe to UART.
- uart_tx_en  out  1  txEn value written with uart_wr_cr; constant 1 after reset.
- uart_tx_start  out  1  txStart value written with uart_wr_cr.
- uart_tx_busy  in  1  transmitter busy (txClk domain, asynchronous here).
- uart_tx_done  in  1  transmitter done (txClk domain, asynchronous here).
- err  out  1  sticky timeout flag; cleared only by reset.

## Operation
- Reset values: push_ready=1, level=0, all uart_* outputs 0, uart_data=0, err=0, state INIT.
- uart_tx_busy and uart_tx_done each pass through a two-flop synchroniser (busy_s, done_s) before use.
- Every strobe is high for exactly 1 cycle and is followed by at least 1 low cycle. The UART detects rising edges, so no strobe is ever held across 2 consecutive cycles.
- State machine, with all outputs registered:
  - INIT: pulse uart_wr_cr with tx_start=0, tx_en=1. This clears any stale start bit in the UART, which is not reset by rst_n. Next state is IDLE.
  - IDLE: if the FIFO is non-empty, pop the head into uart_data and go to LOAD.
  - LOAD: uart_wr_data=1. Next state is START_GAP.
  - START_GAP: 1 low cycle. Next state is START.
  - START: uart_wr_cr=1, tx_start=1. Next state is WAIT_BUSY.
  - WAIT_BUSY: wait for busy_s=1, then go to WAIT_DONE.
  - WAIT_DONE: wait for done_s=1 or busy_s=0, then go to STOP.
  - STOP: uart_wr_cr=1, tx_start=0. Next state is STOP_GAP.
  - STOP_GAP: 1 low cycle. Next state is IDLE.
- Timeout: a counter runs in WAIT_BUSY and WAIT_DONE. When it reaches TIMEOUT-1, set err=1 and go to STOP. The byte is considered consumed.
- FIFO:
  - Circular buffer with read/write pointers of width $clog2(DEPTH)+1; wrap is by MSB compare.
  - Pop occurs only in IDLE, and only when level>0.
- Simultaneous push and pop: level is unchanged and both are performed. A push while full is ignored, since push_ready=0 in that case.
- Flush: pointers reset and level=0 next cycle. The byte already popped still completes its full sequence. A push in the same cycle as flush is dropped.
- Asynchronous reset mid-byte: state returns to INIT and the FIFO is emptied. The transmission in flight in the UART is not aborted, but INIT clears txStart.

## Timing
- Push accepted at edge N: level increments at N+1.
- IDLE with a non-empty FIFO at edge N: uart_wr_data is high at N+2, and uart_wr_cr (start) is high at N+4.
- Minimum strobe spacing is 2 cycles, which is met by the GAP states.
- Per-byte overhead outside the WAIT states is 6 clk cycles. Throughput is otherwise bound by the transmitter plus 2 synchroniser cycles on each status edge.
- push_ready and level reflect the state after the current edge's push/pop. They are combinational from registers only.

## Structure
- Shared package uart_pkg: the state enum (INIT, IDLE, LOAD, START_GAP, START, WAIT_BUSY, WAIT_DONE, STOP, STOP_GAP) and the constant GAP_CYCLES=1.
- One sub-module, uart_sync_fifo (DEPTH, WIDTH=8), with push/pop/flush/level/full/empty. The sequencer and synchronisers live in the top.

## Test plan
- Push 0x55 into an empty FIFO, with a model that raises busy 3 cycles after start and raises done 20 cycles later → uart_data=0x55, wr_data at N+2, wr_cr with start=1 at N+4, wr_cr with start=0 after done_s, err=0.
- Push 16 bytes 0x00..0x0F back-to-back with DEPTH=16 → push_ready=0 after 16 accepts, and the 17th push is rejected. Bytes are emitted in order, and level reaches 0 after the final STOP.
- Push and pop in the same cycle at level=5 → level stays 5.
- Assert flush while byte 0xA1 is in WAIT_DONE with 3 bytes queued → 0xA1 completes, level=0, and no further wr_data is issued.
- Busy never asserts, with TIMEOUT=64 → err=1 64 cycles after entering WAIT_BUSY, then STOP is issued and the next byte proceeds.
- Assert rst_n low during WAIT_DONE → all outputs 0 immediately. After release, the INIT wr_cr pulse has start=0 and level=0.
